// File: rtl/nios2_mul_pkg.sv
// Shared types for the Nios II multiplier cell and its combine stage.
// The cell and the combine stage both see the partial products as mul_pp_t.
package nios2_mul_pkg;

   localparam int MUL_W  = 32;
   localparam int HALF_W = 16;

   typedef struct packed {
      logic [MUL_W-1:0] p1;
      logic [MUL_W-1:0] p2;
      logic [MUL_W-1:0] p3;
   } mul_pp_t;

   // Cross terms only matter mod 2^32, so their low halves suffice.
   function automatic logic [HALF_W-1:0] mid_sum(input mul_pp_t pp);
      return pp.p2[HALF_W-1:0] + pp.p3[HALF_W-1:0];
   endfunction

endpackage

// File: rtl/nios2_mul_pipe_reg.sv
// Valid + payload pipeline register with load enable and flush.
// Flush clears the valid bit only; the payload may go stale.
module nios2_mul_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (en)
            out_valid <= in_valid;
         if (en)
            out_data <= in_data;
      end
   end

endmodule

// File: rtl/camera_qsys_nios2_gen2_cpu_mult_combine.sv
// Combines three 16x16 partial products into the low 32 bits of a
// 32x32 product through a two-stage stallable valid/ready pipeline.
module camera_qsys_nios2_gen2_cpu_mult_combine
   import nios2_mul_pkg::*;
#(
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MUL_W-1:0] in_p1,
   input  logic [MUL_W-1:0] in_p2,
   input  logic [MUL_W-1:0] in_p3,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MUL_W-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] done_count
);

   localparam int S1_W = MUL_W + HALF_W + TAG_W;
   localparam int S2_W = MUL_W + TAG_W;

   mul_pp_t             pp;
   logic                advance;
   logic                accept;
   logic                handoff;
   logic                s1_valid;
   logic [S1_W-1:0]     s1_in;
   logic [S1_W-1:0]     s1_q;
   logic [MUL_W-1:0]    s1_p1;
   logic [HALF_W-1:0]   s1_mid;
   logic [TAG_W-1:0]    s1_tag;
   logic [S2_W-1:0]     s2_in;
   logic [S2_W-1:0]     s2_q;
   logic                unused_hi;

   assign pp        = '{p1: in_p1, p2: in_p2, p3: in_p3};
   assign unused_hi = ^{in_p2[MUL_W-1:HALF_W], in_p3[MUL_W-1:HALF_W]};

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;
   assign handoff  = out_valid && out_ready;

   assign s1_in = {pp.p1, mid_sum(pp), in_tag};

   nios2_mul_pipe_reg #(.W(S1_W)) u_s1 (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .flush     (flush),
      .in_valid  (accept),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_data  (s1_q)
   );

   assign {s1_p1, s1_mid, s1_tag} = s1_q;
   assign s2_in = {s1_p1 + {s1_mid, {HALF_W{1'b0}}}, s1_tag};

   nios2_mul_pipe_reg #(.W(S2_W)) u_s2 (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .flush     (flush),
      .in_valid  (s1_valid),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_data  (s2_q)
   );

   assign {out_result, out_tag} = s2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         done_count <= '0;
      else if (handoff && done_count != {CNT_W{1'b1}})
         done_count <= done_count + CNT_W'(1);
   end

endmodule
